// File: rtl/video_mon_pkg.sv
// Shared types and constants for the video timing monitor.
package video_mon_pkg;

    typedef enum logic [1:0] {
        ACQ_H,
        ACQ_V,
        TRACK
    } vmon_state_t;

    localparam int ERR_W    = 4;
    localparam int ERR_HLEN = 0;
    localparam int ERR_HSW  = 1;
    localparam int ERR_VLEN = 2;
    localparam int ERR_VSW  = 3;

endpackage

// File: rtl/vmon_pulse_meter.sv
// Sync pulse meter: edge detection on a sample strobe, saturating period and
// width counters advanced by a separate count strobe.
module vmon_pulse_meter #(
    parameter int   CNT_W = 12,
    parameter logic POL   = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             smp,
    input  logic             cnt_en,
    input  logic             sync,
    output logic             lead,
    output logic             trail,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] width
);

    logic             s;
    logic             act;
    logic             s_act;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] wid_cnt;

    assign act   = (sync == POL);
    assign s_act = (s == POL);
    assign lead  = smp && act && !s_act;
    assign trail = smp && !act && s_act;

    // A count strobe coinciding with the leading edge belongs to the period being closed.
    assign period = (cnt_en && !(&per_cnt)) ? per_cnt + 1'b1 : per_cnt;
    assign width  = wid_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s       <= ~POL;
            per_cnt <= '0;
            wid_cnt <= '0;
        end else if (smp) begin
            s <= sync;
            if (lead)
                per_cnt <= '0;
            else if (cnt_en && !(&per_cnt))
                per_cnt <= per_cnt + 1'b1;
            if (lead)
                wid_cnt <= cnt_en ? CNT_W'(1) : '0;
            else if (act && cnt_en && !(&wid_cnt))
                wid_cnt <= wid_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_monitor.sv
// Measures line/frame timing and sync widths of a VGA-style stream, keeps a
// per-frame pixel checksum and flags deviations from the expected timing.
//
// state | meaning
// ACQ_H | waiting for first hsync leading edge, nothing latched
// ACQ_V | line measurements live, waiting for first vsync leading edge
// TRACK | all measurements live and checked, lock tracking active
module video_timing_monitor
    import video_mon_pkg::*;
#(
    parameter int   RGB_W       = 3,
    parameter int   PIX_DIV     = 2,
    parameter logic H_POL       = 1'b0,
    parameter logic V_POL       = 1'b0,
    parameter int   EXP_H_TOTAL = 800,
    parameter int   EXP_H_SYNC  = 96,
    parameter int   EXP_V_TOTAL = 525,
    parameter int   EXP_V_SYNC  = 2,
    parameter int   CNT_W       = 12,
    parameter int   CSUM_W      = 16,
    parameter int   FRAME_W     = 16,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [RGB_W-1:0]   rgb,
    input  logic               clr_err,
    output logic [CNT_W-1:0]   line_len,
    output logic [CNT_W-1:0]   hs_width,
    output logic [CNT_W-1:0]   frame_lines,
    output logic [CNT_W-1:0]   vs_width,
    output logic [CSUM_W-1:0]  csum,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               frame_done,
    output logic [ERR_W-1:0]   err,
    output logic               locked
);

    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CLEAN_W = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

    logic [DIV_W-1:0]   div;
    logic               pe;
    logic               h_lead, h_trail, v_lead, v_trail;
    logic [CNT_W-1:0]   h_per, h_wid, v_per, v_wid;
    logic [CSUM_W-1:0]  acc;
    logic               syncs_idle;
    logic [ERR_W-1:0]   mism;
    logic [CLEAN_W-1:0] clean;
    logic               dirty;
    vmon_state_t        state;

    assign pe = (div == DIV_W'(PIX_DIV - 1));

    always_ff @(posedge clk) begin
        if (!resetn)
            div <= '0;
        else if (pe)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    vmon_pulse_meter #(.CNT_W(CNT_W), .POL(H_POL)) u_hmeter (
        .clk    (clk),
        .resetn (resetn),
        .smp    (pe),
        .cnt_en (pe),
        .sync   (hsync),
        .lead   (h_lead),
        .trail  (h_trail),
        .period (h_per),
        .width  (h_wid)
    );

    // Vertical meter samples vsync per pixel but counts lines.
    vmon_pulse_meter #(.CNT_W(CNT_W), .POL(V_POL)) u_vmeter (
        .clk    (clk),
        .resetn (resetn),
        .smp    (pe),
        .cnt_en (h_lead),
        .sync   (vsync),
        .lead   (v_lead),
        .trail  (v_trail),
        .period (v_per),
        .width  (v_wid)
    );

    assign syncs_idle = (hsync != H_POL) && (vsync != V_POL);

    always_ff @(posedge clk) begin
        if (!resetn)
            acc <= '0;
        else if (pe) begin
            if (v_lead)
                acc <= '0;
            else if (syncs_idle)
                acc <= acc + CSUM_W'(rgb);
        end
    end

    always_comb begin
        mism = '0;
        if (state == TRACK) begin
            mism[ERR_HLEN] = h_lead  && (h_per != CNT_W'(EXP_H_TOTAL));
            mism[ERR_HSW]  = h_trail && (h_wid != CNT_W'(EXP_H_SYNC));
            mism[ERR_VLEN] = v_lead  && (v_per != CNT_W'(EXP_V_TOTAL));
            mism[ERR_VSW]  = v_trail && (v_wid != CNT_W'(EXP_V_SYNC));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ACQ_H;
            line_len    <= '0;
            hs_width    <= '0;
            frame_lines <= '0;
            vs_width    <= '0;
            csum        <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
            err         <= '0;
            locked      <= 1'b0;
            clean       <= '0;
            dirty       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= (clr_err ? '0 : err) | mism;
            case (state)
                ACQ_H: begin
                    if (h_lead)
                        state <= ACQ_V;
                end
                ACQ_V: begin
                    if (h_lead)
                        line_len <= h_per;
                    if (h_trail)
                        hs_width <= h_wid;
                    if (v_lead)
                        state <= TRACK;
                end
                TRACK: begin
                    if (h_lead)
                        line_len <= h_per;
                    if (h_trail)
                        hs_width <= h_wid;
                    if (v_trail)
                        vs_width <= v_wid;
                    if (v_lead) begin
                        frame_lines <= v_per;
                        csum        <= acc;
                        frame_cnt   <= frame_cnt + 1'b1;
                        frame_done  <= 1'b1;
                        if (!dirty && (mism == '0)) begin
                            if (int'(clean) < LOCK_FRAMES)
                                clean <= clean + 1'b1;
                            if (int'(clean) + 1 >= LOCK_FRAMES)
                                locked <= 1'b1;
                        end
                    end
                    // A mismatch on the boundary itself is charged to the frame that just closed.
                    if (v_lead)
                        dirty <= 1'b0;
                    else if (|mism)
                        dirty <= 1'b1;
                    if (|mism) begin
                        clean  <= '0;
                        locked <= 1'b0;
                    end
                end
                default: state <= ACQ_H;
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboard bench: two monitors (PIX_DIV=2 active-low syncs, PIX_DIV=1 active-high syncs).
module tb_video_timing_monitor;

    localparam logic HP_A = 1'b0, VP_A = 1'b0;
    localparam logic HP_B = 1'b1, VP_B = 1'b1;

    typedef struct packed {
        logic [11:0] ll;
        logic [11:0] hs;
        logic [11:0] fl;
        logic [11:0] vs;
        logic [15:0] cs;
        logic [15:0] fc;
        logic [3:0]  er;
        logic        lk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, hs_a, vs_a, clr_a, fd_o_a, lk_a;
    logic [2:0]  rgb_a;
    logic [11:0] ll_a, hw_a, fl_a, vw_a;
    logic [15:0] cs_a, fc_a;
    logic [3:0]  err_a;

    logic        rst_b, hs_b, vs_b, clr_b, fd_o_b, lk_b;
    logic [2:0]  rgb_b;
    logic [11:0] ll_b, hw_b, fl_b, vw_b;
    logic [15:0] cs_b, fc_b;
    logic [3:0]  err_b;

    exp_t got_a, got_b;
    assign got_a = {ll_a, hw_a, fl_a, vw_a, cs_a, fc_a, err_a, lk_a};
    assign got_b = {ll_b, hw_b, fl_b, vw_b, cs_b, fc_b, err_b, lk_b};

    video_timing_monitor #(
        .RGB_W(3), .PIX_DIV(2), .H_POL(HP_A), .V_POL(VP_A),
        .EXP_H_TOTAL(10), .EXP_H_SYNC(2), .EXP_V_TOTAL(6), .EXP_V_SYNC(1),
        .CNT_W(12), .CSUM_W(16), .FRAME_W(16), .LOCK_FRAMES(2)
    ) u_a (
        .clk(clk), .resetn(rst_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a),
        .clr_err(clr_a), .line_len(ll_a), .hs_width(hw_a), .frame_lines(fl_a),
        .vs_width(vw_a), .csum(cs_a), .frame_cnt(fc_a), .frame_done(fd_o_a),
        .err(err_a), .locked(lk_a)
    );

    video_timing_monitor #(
        .RGB_W(3), .PIX_DIV(1), .H_POL(HP_B), .V_POL(VP_B),
        .EXP_H_TOTAL(10), .EXP_H_SYNC(2), .EXP_V_TOTAL(6), .EXP_V_SYNC(1),
        .CNT_W(12), .CSUM_W(16), .FRAME_W(16), .LOCK_FRAMES(2)
    ) u_b (
        .clk(clk), .resetn(rst_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b),
        .clr_err(clr_b), .line_len(ll_b), .hs_width(hw_b), .frame_lines(fl_b),
        .vs_width(vw_b), .csum(cs_b), .frame_cnt(fc_b), .frame_done(fd_o_b),
        .err(err_b), .locked(lk_b)
    );

    int   tests = 0;
    int   fails = 0;
    int   fd_a  = 0;
    int   fd_b  = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic cmp(input string p, input exp_t g, input exp_t e);
        chk({p, "_line_len"},    32'(g.ll), 32'(e.ll));
        chk({p, "_hs_width"},    32'(g.hs), 32'(e.hs));
        chk({p, "_frame_lines"}, 32'(g.fl), 32'(e.fl));
        chk({p, "_vs_width"},    32'(g.vs), 32'(e.vs));
        chk({p, "_csum"},        32'(g.cs), 32'(e.cs));
        chk({p, "_frame_cnt"},   32'(g.fc), 32'(e.fc));
        chk({p, "_err"},         32'(g.er), 32'(e.er));
        chk({p, "_locked"},      32'(g.lk), 32'(e.lk));
    endtask

    // Nominal frame: 10-pixel lines, 6 lines, 1-line vsync, 7 ones x 5 lines.
    function automatic exp_t mk(input int fc, input logic [3:0] er, input logic lk);
        exp_t e;
        e.ll = 12'd10;
        e.hs = 12'd2;
        e.fl = 12'd6;
        e.vs = 12'd1;
        e.cs = 16'd35;
        e.fc = fc[15:0];
        e.er = er;
        e.lk = lk;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_a && fd_o_a) begin
            fd_a++;
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL fd_unexpected_a: frame_done got 1, expected 0");
            end else
                cmp("a", got_a, q_a.pop_front());
        end
        if (rst_b && fd_o_b) begin
            fd_b++;
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL fd_unexpected_b: frame_done got 1, expected 0");
            end else
                cmp("b", got_b, q_b.pop_front());
        end
    end

    task automatic chk_zero_a(input string p);
        cmp(p, got_a, exp_t'(0));
        chk({p, "_frame_done"}, 32'(fd_o_a), 0);
    endtask

    // Entered on a negedge right after a pe edge; holds one pixel for PIX_DIV clocks.
    task automatic pix(input bit b, input bit ha, input bit va, input logic [2:0] r, input bit clr);
        if (!b) begin
            hs_a  = ha ? HP_A : ~HP_A;
            vs_a  = va ? VP_A : ~VP_A;
            rgb_a = r;
            clr_a = clr;
            repeat (2) @(negedge clk);
        end else begin
            hs_b  = ha ? HP_B : ~HP_B;
            vs_b  = va ? VP_B : ~VP_B;
            rgb_b = r;
            clr_b = clr;
            @(negedge clk);
        end
    endtask

    task automatic frame(input bit b, input int vs_off, input int sl, input int slen,
                         input bit do_clr, input bit do_rst);
        int         len;
        bit         ha, va, ev;
        logic [2:0] r;
        for (int l = 0; l < 6; l++) begin
            len = (l == sl) ? slen : 10;
            for (int x = 0; x < len; x++) begin
                ha = (x < 2);
                va = (l == 0 && x >= vs_off) || (l == 1 && x < vs_off);
                r  = (ha || va) ? 3'd7 : ((l >= 1 && x >= len - 7) ? 3'd1 : 3'd0);
                ev = (l == 2 && x == 5);
                pix(b, ha, va, r, do_clr && ev);
                if (sl >= 0 && l == sl + 1 && x == 0) begin
                    chk("odd_line_len",    32'(ll_a),  (slen > 4095) ? 4095 : slen);
                    chk("odd_line_err",    32'(err_a), 1);
                    chk("odd_line_locked", 32'(lk_a),  0);
                end
                if (do_clr && ev) begin
                    chk("clr_err_err",    32'(err_a), 0);
                    chk("clr_err_locked", 32'(lk_a),  1);
                end
                if (do_rst && ev) begin
                    rst_a = 1'b0;
                    @(negedge clk);
                    chk_zero_a("midrst");
                    rst_a = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int n0;
        rst_a = 1'b0; hs_a = ~HP_A; vs_a = ~VP_A; rgb_a = '0; clr_a = 1'b0;
        rst_b = 1'b0; hs_b = ~HP_B; vs_b = ~VP_B; rgb_b = '0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_a("rst");
        chk("rst_b_any", 32'(|got_b), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        frame(0, 3, -1, 10, 0, 0);
        q_a.push_back(mk(1, 4'b0000, 1'b0)); frame(0, 3, -1, 10, 0, 0);
        q_a.push_back(mk(2, 4'b0000, 1'b1)); frame(0, 3, 3, 11, 0, 0);
        q_a.push_back(mk(3, 4'b0001, 1'b0)); frame(0, 3, -1, 10, 0, 0);
        q_a.push_back(mk(4, 4'b0001, 1'b0)); frame(0, 3, -1, 10, 0, 0);
        q_a.push_back(mk(5, 4'b0001, 1'b1)); frame(0, 3, -1, 10, 1, 0);
        q_a.push_back(mk(6, 4'b0000, 1'b1)); frame(0, 0, -1, 10, 0, 0);
        q_a.push_back(mk(7, 4'b0000, 1'b1)); frame(0, 0, -1, 10, 0, 0);
        q_a.push_back(mk(8, 4'b0000, 1'b1)); frame(0, 3, 3, 5002, 0, 0);
        q_a.push_back(mk(9, 4'b0001, 1'b0)); frame(0, 3, -1, 10, 0, 1);
        n0 = fd_a;
        frame(0, 3, -1, 10, 0, 0);
        chk("no_fd_after_rst", fd_a - n0, 0);
        q_a.push_back(mk(1, 4'b0000, 1'b0)); frame(0, 3, -1, 10, 0, 0);
        chk("a_fd_total", fd_a, 10);

        frame(1, 3, -1, 10, 0, 0);
        q_b.push_back(mk(1, 4'b0000, 1'b0)); frame(1, 3, -1, 10, 0, 0);
        q_b.push_back(mk(2, 4'b0000, 1'b1)); frame(1, 3, -1, 10, 0, 0);
        chk("b_fd_total", fd_b, 2);

        repeat (4) @(negedge clk);
        chk("q_a_left", q_a.size(), 0);
        chk("q_b_left", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_monitor.md
# video_timing_monitor

Parametrised, synthesizable successor to the text-dump frame logger. It watches a one-clock-domain VGA-style stream of `hsync`, `vsync` and `rgb` at a configurable pixel rate. It measures line length, lines per frame and both sync widths, keeps a per-frame pixel checksum, and flags mismatches against the expected timing. It sits beside any `wrapper_*` video source in both simulation and FPGA builds, so benches check numbers instead of reading ASCII frames.

## Interface
- `RGB_W`, 3, colour bus width
- `PIX_DIV`, 2, clocks per pixel (≥1)
- `H_POL`, 0, active level of hsync pulse
- `V_POL`, 0, active level of vsync pulse
- `EXP_H_TOTAL`, 800, expected pixels per line
- `EXP_H_SYNC`, 96, expected hsync width (pixels)
- `EXP_V_TOTAL`, 525, expected lines per frame
- `EXP_V_SYNC`, 2, expected vsync width (lines)
- `CNT_W`, 12, width of all measurement counters
- `CSUM_W`, 16, checksum width
- `FRAME_W`, 16, frame counter width
- `LOCK_FRAMES`, 2, clean frames required for lock
- `clk  in  1  system clock`
- `resetn  in  1  reset, synchronous, active-low`
- `hsync  in  1  monitored hsync`
- `vsync  in  1  monitored vsync`
- `rgb  in  RGB_W  monitored colour`
- `clr_err  in  1  clears sticky error flags`
- `line_len  out  CNT_W  last complete line length, pixels`
- `hs_width  out  CNT_W  last hsync width, pixels`
- `frame_lines  out  CNT_W  last complete frame, lines`
- `vs_width  out  CNT_W  last vsync width, lines`
- `csum  out  CSUM_W  checksum of last complete frame`
- `frame_cnt  out  FRAME_W  complete frames seen, wraps`
- `frame_done  out  1  one-clock pulse per frame boundary`
- `err  out  4  sticky {vs_width, frame_lines, hs_width, line_len} mismatch`
- `locked  out  1  LOCK_FRAMES consecutive clean frames`

## Operation
- Pixel strobe `pe`: a free-running divider counts 0..PIX_DIV-1 from reset. `pe` is high when the count is PIX_DIV-1, and high every clock when PIX_DIV=1.
- On each `pe`, the inputs are compared with the previous sample register `s`, and `s` then updates. A leading edge is inactive→active; a trailing edge is active→inactive.
- Horizontal:
  - `h_cnt` counts `pe`.
  - An hsync leading edge latches `h_cnt+1` into `line_len` and clears `h_cnt`.
  - `hs_cnt` counts `pe` while hsync is active; the trailing edge latches it into `hs_width`.
- Vertical:
  - `v_cnt` counts hsync leading edges.
  - A vsync leading edge latches `v_cnt` into `frame_lines` and clears it. If the hsync and vsync leading edges fall on the same `pe`, the line is counted first and included in the latched value.
  - `vs_cnt` counts hsync leading edges while vsync is active; the vsync trailing edge latches it into `vs_width`.
- Checksum: sum of `rgb` modulo 2^CSUM_W over `pe` samples where neither sync is active. A vsync leading edge latches the sum into `csum` and restarts it from 0.
- All counters saturate at all-ones and never wrap. `frame_cnt` wraps.
- FSM:
  - ACQ_H: wait for the first hsync leading edge. Nothing is latched.
  - ACQ_V: line measurements are live. Wait for the first vsync leading edge; `frame_lines`, `csum` and `frame_cnt` are not updated on it.
  - TRACK: all measurements are live. Each latch is compared with its EXP_*; a mismatch sets its `err` bit.
- Lock:
  - The clean-frame counter increments at each frame boundary in TRACK when no mismatch occurred during the frame.
  - `locked` rises when the counter reaches LOCK_FRAMES.
  - Any mismatch clears the counter and `locked` on the same clock as the `err` set.
- `clr_err` clears `err` only. If `clr_err` and a new mismatch occur on the same clock, the set wins.

## Timing
- Reset values: all outputs 0, FSM = ACQ_H, divider 0, `s` = inactive levels.
- Latency: every latch, `err` set and `frame_done` appear on the clock edge after the `pe` cycle that sampled the edge, i.e. 1 clk. `frame_done` is high for exactly 1 clk, and only in TRACK.
- Reset mid-frame: the next clock with `resetn`=0 restores all reset values regardless of FSM state. Measurement then restarts at ACQ_H.
- A source stall (no hsync edge) saturates `h_cnt`. The next line latches all-ones and flags `err[0]`.

## Structure
- Package `video_mon_pkg` holds:
  - FSM enum `vmon_state_t` {ACQ_H, ACQ_V, TRACK};
  - `err` bit index constants `ERR_HLEN`, `ERR_HSW`, `ERR_VLEN`, `ERR_VSW`.
- Sub-module `vmon_pulse_meter`, parametrised by CNT_W and polarity, instantiated twice (H and V). It takes a count strobe and a sync input, and outputs leading/trailing edge pulses, the period count and the width count. Horizontal uses the strobe `pe`; vertical uses the hsync leading edge.
- Divider, checksum, FSM and lock logic live in the top module.

## Test plan
Test parameters: PIX_DIV=2, EXP_H_TOTAL=10, EXP_H_SYNC=2, EXP_V_TOTAL=6, EXP_V_SYNC=1, LOCK_FRAMES=2, RGB_W=3.

1. Reset, then 3 clean frames with rgb=1 during active pixels (7 per line, 5 active lines). Required: `line_len`=10, `hs_width`=2, `frame_lines`=6, `vs_width`=1, `csum`=35, `frame_cnt`=2, `locked` rises at the 2nd `frame_done`, `err`=0.
2. From lock, make one line 11 pixels. Required: `err[0]`=1 and `locked`=0 1 clk after that hsync edge sample. After 2 further clean frames `locked`=1 again and `err[0]` stays 1. Pulse `clr_err` → `err`=0.
3. Assert hsync and vsync leading edges on the same `pe`. Required: `frame_lines`=6 (the line is counted), no error.
4. Hold hsync inactive for 5000 pixels. Required: `line_len`=4095 at the next edge and `err[0]`=1.
5. Pull `resetn` low for 1 clk mid-frame. Required: all outputs 0 on the next clock, no `frame_done` on the first vsync edge afterwards, `frame_cnt`=1 after the second vsync edge.
6. PIX_DIV=1 rerun of scenario 1. Required: identical measured values.
